// File: rtl/spi_register_file.sv
// SPI-addressable register bank: atomic multi-byte writes, coherent snapshot reads of live status.
// Latency: response 1 cycle after operand count, commit/strobe 1 cycle after release; no backpressure.
module spi_register_file #(
    parameter logic [7:0] BASE_ADDRESS   = 8'h20,
    parameter int         REGISTER_COUNT = 4,
    parameter int         REGISTER_BYTES = 2,
    parameter logic [REGISTER_COUNT*REGISTER_BYTES*8-1:0] RESET_VALUE = '0,
    parameter logic [REGISTER_COUNT-1:0] WRITABLE_MASK = 4'b0111
) (
    input  logic                                      clock_in,
    input  logic                                      reset_in,
    input  logic [7:0]                                opcode_in,
    input  logic                                      opcode_valid_in,
    input  logic [7:0]                                operand_in,
    input  logic                                      operand_valid_in,
    input  logic [31:0]                               operand_count_in,
    input  logic [REGISTER_COUNT*REGISTER_BYTES*8-1:0] status_values_in,
    output logic [7:0]                                response_out,
    output logic                                      response_valid_out,
    output logic [REGISTER_COUNT*REGISTER_BYTES*8-1:0] register_values_out,
    output logic [REGISTER_COUNT-1:0]                 register_write_strobe_out
);
    localparam int W     = REGISTER_BYTES * 8;
    localparam int IDX_W = (REGISTER_COUNT > 1) ? $clog2(REGISTER_COUNT) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_IGNORE = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    logic [1:0]                  r_state;
    logic                        r_opcode_valid;
    logic                        r_pending;
    logic [IDX_W-1:0]            r_index;
    logic [W-1:0]                r_snapshot;
    logic [W-1:0]                r_shadow;
    logic [REGISTER_BYTES-1:0]   r_mask;
    logic [REGISTER_COUNT*W-1:0] r_regs;
    logic [REGISTER_COUNT-1:0]   r_strobe;
    logic [7:0]                  r_response;
    logic                        r_response_valid;

    logic                        w_rise;
    logic [8:0]                  w_offset;
    logic                        w_in_range;
    logic [IDX_W-1:0]            w_new_index;
    logic                        w_start;
    logic                        w_entry;
    logic [IDX_W-1:0]            w_sel_index;
    logic                        w_sel_writable;
    logic [W-1:0]                w_snap_src;
    logic [W-1:0]                w_shadow_next;
    logic [REGISTER_BYTES-1:0]   w_mask_next;
    logic [7:0]                  w_read_byte;
    logic [1:0]                  w_state_next;
    logic                        w_commit;

    assign w_rise      = opcode_valid_in & ~r_opcode_valid;
    assign w_offset    = {1'b0, opcode_in} - {1'b0, BASE_ADDRESS};
    assign w_in_range  = ~w_offset[8] && (w_offset < 9'(REGISTER_COUNT));
    assign w_new_index = w_offset[IDX_W-1:0];

    // A rising edge seen during COMMIT is replayed from r_pending in the next IDLE cycle.
    assign w_start     = (r_state == ST_IDLE) && opcode_valid_in && (w_rise || r_pending);
    assign w_entry     = w_start && w_in_range;

    assign w_sel_index    = w_entry ? w_new_index : r_index;
    assign w_sel_writable = WRITABLE_MASK[w_sel_index];

    // On entry the read path uses the value being snapshotted so the first byte is valid at once.
    assign w_snap_src = !w_entry       ? r_snapshot :
                        w_sel_writable ? r_regs[w_sel_index*W +: W] :
                                         status_values_in[w_sel_index*W +: W];

    always_comb begin
        w_shadow_next = r_shadow;
        w_mask_next   = r_mask;
        w_read_byte   = 8'h00;
        for (int b = 0; b < REGISTER_BYTES; b++) begin
            if (operand_count_in == 32'(b)) begin
                w_read_byte = w_snap_src[(REGISTER_BYTES-1-b)*8 +: 8];
                if (r_state == ST_ACTIVE && operand_valid_in) begin
                    w_shadow_next[(REGISTER_BYTES-1-b)*8 +: 8] = operand_in;
                    w_mask_next[b] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_start) w_state_next = w_in_range ? ST_ACTIVE : ST_IGNORE;
            ST_ACTIVE: if (!opcode_valid_in)
                           w_state_next = (w_sel_writable && (&w_mask_next)) ? ST_COMMIT : ST_IDLE;
            ST_IGNORE: if (!opcode_valid_in) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    assign w_commit = (r_state == ST_ACTIVE) && (w_state_next == ST_COMMIT);

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_state          <= ST_IDLE;
            // Track the live level so a transaction still open at release is not seen as a new edge.
            r_opcode_valid   <= opcode_valid_in;
            r_pending        <= 1'b0;
            r_index          <= '0;
            r_snapshot       <= '0;
            r_shadow         <= '0;
            r_mask           <= '0;
            r_regs           <= RESET_VALUE;
            r_strobe         <= '0;
            r_response       <= 8'h00;
            r_response_valid <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_opcode_valid <= opcode_valid_in;
            r_pending      <= (r_state == ST_COMMIT) && w_rise;
            if (w_entry) begin
                r_index    <= w_new_index;
                r_snapshot <= w_snap_src;
                r_shadow   <= '0;
                r_mask     <= '0;
            end else if (r_state == ST_ACTIVE) begin
                r_shadow <= w_shadow_next;
                r_mask   <= w_mask_next;
            end
            r_strobe <= '0;
            if (w_commit) begin
                r_regs[r_index*W +: W] <= w_shadow_next;
                r_strobe[r_index]      <= 1'b1;
            end
            r_response_valid <= (w_state_next == ST_ACTIVE);
            r_response       <= (w_state_next == ST_ACTIVE) ? w_read_byte : 8'h00;
        end
    end

    assign response_out              = r_response;
    assign response_valid_out        = r_response_valid;
    assign register_values_out       = r_regs;
    assign register_write_strobe_out = r_strobe;

endmodule
